// File: rtl/csr_reg_file.sv
// rtl/csr_reg_file.sv - parametrised CSR register file with byte strobes and W1C status region
// Optional macro CSR_REG_FILE_RDW_FORWARD_EN: same-cycle read of a written index returns the post-update value.
module csr_reg_file #(
    parameter int                 DATA_W      = 32,
    parameter int                 ADDR_W      = 12,
    parameter int                 DEPTH       = 64,
    parameter int                 W1C_BASE    = 48,
    parameter logic [DATA_W-1:0]  RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    csr_read,
    input  logic [ADDR_W-1:0]       csr_read_addr,
    output logic [DATA_W-1:0]       csr_read_data,
    output logic                    csr_read_valid,
    input  logic                    csr_write,
    input  logic [ADDR_W-1:0]       csr_write_addr,
    input  logic [DATA_W-1:0]       csr_write_data,
    input  logic [DATA_W/8-1:0]     csr_write_strb,
    output logic                    csr_addr_err,
    input  logic [DEPTH*DATA_W-1:0] hw_set,
    output logic [DEPTH*DATA_W-1:0] reg_q
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [DATA_W-1:0] reg_next [DEPTH];
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] rd_val;
    logic              rd_in_range;
    logic              wr_in_range;

    assign rd_in_range = {1'b0, csr_read_addr} < DEPTH_W;
    assign wr_in_range = {1'b0, csr_write_addr} < DEPTH_W;

    // Out-of-range write addresses never match any index, so they fall out naturally.
    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (csr_write_strb[b]) begin
                wmask[8*b +: 8] = 8'hFF;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (k < W1C_BASE) begin
                reg_next[k] = (csr_write && (csr_write_addr == ADDR_W'(k)))
                            ? ((regs[k] & ~wmask) | (csr_write_data & wmask))
                            : regs[k];
            end else begin
                reg_next[k] = (regs[k] & ~((csr_write && (csr_write_addr == ADDR_W'(k)))
                                           ? (csr_write_data & wmask) : '0))
                            | hw_set[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (csr_read_addr == ADDR_W'(k)) begin
`ifdef CSR_REG_FILE_RDW_FORWARD_EN
                rd_val = reg_next[k];
`else
                rd_val = regs[k];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= (k < W1C_BASE) ? RESET_VALUE : '0;
            end
            csr_read_data  <= '0;
            csr_read_valid <= 1'b0;
            csr_addr_err   <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= reg_next[k];
            end
            if (csr_read) begin
                csr_read_data <= rd_val;
            end
            csr_read_valid <= csr_read;
            csr_addr_err   <= (csr_read && !rd_in_range) || (csr_write && !wr_in_range);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

    // Set requests aimed at control registers carry no meaning.
    if (W1C_BASE > 0) begin : g_unused
        logic unused_hw_set;
        assign unused_hw_set = ^hw_set[W1C_BASE*DATA_W-1:0];
    end

endmodule

// File: tb/tb_csr_reg_file.sv
// tb/tb_csr_reg_file.sv - randomized self-checking bench for csr_reg_file against an array model
module tb_csr_reg_file;

    localparam int N  = 64;
    localparam int WB = 48;
    localparam logic [31:0] RV = 32'hA5A5_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            csr_read;
    logic [11:0]     csr_read_addr;
    logic [31:0]     csr_read_data;
    logic            csr_read_valid;
    logic            csr_write;
    logic [11:0]     csr_write_addr;
    logic [31:0]     csr_write_data;
    logic [3:0]      csr_write_strb;
    logic            csr_addr_err;
    logic [N*32-1:0] hw_set;
    logic [N*32-1:0] reg_q;

    csr_reg_file #(
        .DATA_W(32), .ADDR_W(12), .DEPTH(N), .W1C_BASE(WB), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .rst(rst),
        .csr_read(csr_read), .csr_read_addr(csr_read_addr),
        .csr_read_data(csr_read_data), .csr_read_valid(csr_read_valid),
        .csr_write(csr_write), .csr_write_addr(csr_write_addr),
        .csr_write_data(csr_write_data), .csr_write_strb(csr_write_strb),
        .csr_addr_err(csr_addr_err), .hw_set(hw_set), .reg_q(reg_q)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [N];
    logic [31:0] exp_rd;
    logic        exp_v;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [11:0] ra,
                        input logic wr, input logic [11:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [N*32-1:0] hw);
        logic [31:0] old [N];
        logic [31:0] m;
        rst = r; csr_read = rd; csr_read_addr = ra;
        csr_write = wr; csr_write_addr = wa; csr_write_data = wd; csr_write_strb = ws;
        hw_set = hw;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (ws[b]) m = m | (32'hFF << (8*b));
        old = model;
        if (r) begin
            for (int k = 0; k < N; k++) model[k] = (k < WB) ? RV : 32'h0;
            exp_rd = 32'h0; exp_v = 1'b0; exp_err = 1'b0;
        end else begin
            if (wr && wa < N) begin
                if (wa < WB) model[wa] = (model[wa] & ~m) | (wd & m);
                else         model[wa] = model[wa] & ~(wd & m);
            end
            for (int k = WB; k < N; k++) model[k] = model[k] | hw[k*32 +: 32];
            exp_v = rd;
            if (rd) begin
`ifdef CSR_REG_FILE_RDW_FORWARD_EN
                exp_rd = (ra < N) ? model[ra] : 32'h0;
`else
                exp_rd = (ra < N) ? old[ra] : 32'h0;
`endif
            end
            exp_err = (rd && ra >= N) || (wr && wa >= N);
        end
        @(posedge clk);
        #1;
        check("read_valid", {31'b0, csr_read_valid}, {31'b0, exp_v});
        check("addr_err", {31'b0, csr_addr_err}, {31'b0, exp_err});
        check("read_data", csr_read_data, exp_rd);
        for (int k = 0; k < N; k++) check($sformatf("reg_q[%0d]", k), reg_q[k*32 +: 32], model[k]);
    endtask

    function automatic logic [N*32-1:0] hw_bit(input int idx, input logic [31:0] v);
        logic [N*32-1:0] h;
        h = '0;
        h[idx*32 +: 32] = v;
        return h;
    endfunction

    initial begin
        logic [N*32-1:0] h;
        logic [11:0] ra, wa;
        rst = 1'b1; csr_read = 1'b0; csr_read_addr = '0; csr_write = 1'b0;
        csr_write_addr = '0; csr_write_data = '0; csr_write_strb = '0; hw_set = '0;
        for (int k = 0; k < N; k++) model[k] = 32'h0;

        // reset
        step(1, 0, 0, 0, 0, 0, 0, '0);
        check("rst_reg0", reg_q[31:0], 32'hA5A5_0000);
        check("rst_reg50", reg_q[50*32 +: 32], 32'h0);

        // strobed write
        step(0, 0, 0, 1, 3, 32'h1122_3344, 4'hF, '0);
        step(0, 0, 0, 1, 3, 32'hAABB_CCDD, 4'b0101, '0);
        step(0, 1, 3, 0, 0, 0, 0, '0);
        check("strb_read", csr_read_data, 32'h11BB_33DD);
        step(0, 0, 0, 0, 0, 0, 0, '0);
        check("valid_pulse", {31'b0, csr_read_valid}, 32'h0);
        step(0, 0, 0, 1, 7, 32'hFFFF_FFFF, 4'h0, '0);

        // W1C behaviour
        step(0, 0, 0, 0, 0, 0, 0, hw_bit(50, 32'h11));
        step(0, 1, 50, 0, 0, 0, 0, '0);
        check("w1c_set", csr_read_data, 32'h11);
        step(0, 0, 0, 1, 50, 32'h01, 4'hF, '0);
        step(0, 1, 50, 0, 0, 0, 0, '0);
        check("w1c_clr", csr_read_data, 32'h10);
        step(0, 0, 0, 1, 50, 32'h10, 4'hF, hw_bit(50, 32'h10));
        step(0, 1, 50, 0, 0, 0, 0, '0);
        check("w1c_set_wins", csr_read_data, 32'h10);

        // out of range
        step(0, 1, 64, 0, 0, 0, 0, '0);
        check("oor_read", csr_read_data, 32'h0);
        check("oor_err", {31'b0, csr_addr_err}, 32'h1);
        step(0, 0, 0, 1, 100, 32'hFFFF_FFFF, 4'hF, '0);
        step(0, 0, 0, 0, 0, 0, 0, '0);
        check("err_pulse_end", {31'b0, csr_addr_err}, 32'h0);

        // read during write
        step(0, 0, 0, 1, 5, 32'h0, 4'hF, '0);
        step(0, 1, 5, 1, 5, 32'h0000_00FF, 4'hF, '0);
`ifdef CSR_REG_FILE_RDW_FORWARD_EN
        check("rdw_same", csr_read_data, 32'h0000_00FF);
`else
        check("rdw_same", csr_read_data, 32'h0);
`endif
        step(0, 1, 5, 0, 0, 0, 0, '0);
        check("rdw_next", csr_read_data, 32'h0000_00FF);

        // reset mid-stream
        step(0, 1, 2, 1, 9, 32'h1234_5678, 4'hF, '0);
        step(1, 1, 9, 1, 10, 32'hDEAD_BEEF, 4'hF, hw_bit(55, 32'hFF));
        check("mid_rst_reg10", reg_q[10*32 +: 32], 32'hA5A5_0000);
        step(0, 1, 9, 1, 11, 32'h0BAD_F00D, 4'hF, '0);
        check("resume_read", csr_read_data, 32'hA5A5_0000);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            ra = 12'($urandom_range(0, 79));
            wa = 12'($urandom_range(0, 79));
            if (ra >= 12'd72) ra = 12'($urandom_range(64, 4095));
            if (wa >= 12'd72) wa = 12'($urandom_range(64, 4095));
            if ($urandom_range(0, 3) == 0) ra = wa;
            for (int k = 0; k < N; k++)
                h[k*32 +: 32] = (k < WB) ? $urandom : ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 1) == 0) h = '0;
            step(($urandom_range(0, 60) == 0), 1'($urandom), ra, 1'($urandom), wa,
                 $urandom, 4'($urandom), h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_reg_file.md
# csr_reg_file

Synthesizable, parametrised control/status register file that replaces the behavioural CSR simulation memory on the CSR bus of the camera/HDMI pipeline. It provides byte-strobed software writes, a one-cycle registered read with valid flag, out-of-range detection, and a region of hardware-set / software-clear (W1C) status registers. All register contents are exported in parallel to the datapath blocks.

## Interface
Parameters:
- DATA_W, 32, register width in bits; multiple of 8.
- ADDR_W, 12, CSR bus address width.
- DEPTH, 64, number of implemented registers, indices 0..DEPTH-1; DEPTH <= 2**ADDR_W.
- W1C_BASE, 48, first index of the W1C status region (W1C_BASE..DEPTH-1); W1C_BASE = DEPTH means no status region.
- RESET_VALUE, 0, value loaded into every control register (index < W1C_BASE) on reset.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- csr_read  in  1  read request, one per cycle.
- csr_read_addr  in  ADDR_W  read index.
- csr_read_data  out  DATA_W  read result, registered.
- csr_read_valid  out  1  high for one cycle, the cycle after csr_read is accepted.
- csr_write  in  1  write request, one per cycle.
- csr_write_addr  in  ADDR_W  write index.
- csr_write_data  in  DATA_W  write data.
- csr_write_strb  in  DATA_W/8  byte enables; bit i covers data[8i+7:8i].
- csr_addr_err  out  1  one-cycle pulse: read or write to index >= DEPTH.
- hw_set  in  DEPTH*DATA_W  per-bit set requests; only slices for W1C registers used, others ignored.
- reg_q  out  DEPTH*DATA_W  current register contents, slice k = register k.

## Operation
- Reset (rst high at edge): control registers <= RESET_VALUE; W1C registers <= 0; csr_read_data <= 0; csr_read_valid <= 0; csr_addr_err <= 0. Requests in the reset cycle are dropped.
- Control register write (index < W1C_BASE): each byte with strobe 1 takes write data; other bytes unchanged. Strobe all-zero: no change.
- W1C register (W1C_BASE <= index < DEPTH): next = (cur & ~clr) | hw_set_slice, where clr = write data masked by strobes when written, else 0. hw_set wins over simultaneous clear of the same bit. hw_set is sampled every cycle independent of the bus.
- Read: csr_read_data <= register value (index < DEPTH) or 0 (index >= DEPTH); csr_read_valid <= csr_read. When csr_read is low, csr_read_data holds its previous value.
- Out of range: write ignored, no state change; csr_addr_err <= 1 if csr_read or csr_write targets index >= DEPTH (either or both, single pulse).
- Simultaneous read and write to different indices: independent. Same index: see Configuration.
- No backpressure; every request completes.

## Timing
- Write latency: data issued at edge N visible on reg_q after edge N.
- Read latency: 1 cycle; request at edge N, csr_read_data/csr_read_valid valid after edge N, for one cycle (valid) / until next read (data).
- hw_set at edge N appears in reg_q after edge N.
- csr_addr_err aligned with csr_read_valid timing (after the request edge).
- Back-to-back reads/writes at full rate.

## Configuration
- CSR_REG_FILE_RDW_FORWARD_EN defined: read and write to the same index in the same cycle returns the post-update value (strobe merge, W1C clear and hw_set applied).
- Not defined: same-cycle read returns the pre-update value (old data); new value visible to a read issued the following cycle.

## Test plan
- Reset: drive rst 1 cycle with RESET_VALUE=32'hA5A5_0000 -> reg_q slice 0..47 = 32'hA5A5_0000, slice 48..63 = 0, csr_read_valid=0, csr_read_data=0.
- Strobed write: reg 3 = 32'h1122_3344, write 32'hAABB_CCDD strb 4'b0101 -> read reg 3 next cycle = 32'h11BB_33DD, valid pulses 1 cycle.
- W1C: hw_set reg 50 bits 0 and 4 -> reads 32'h11; write 32'h01 -> 32'h10; write 32'h10 with hw_set bit 4 same cycle -> stays 32'h10.
- Out of range: read index 64 -> csr_read_data=0, csr_addr_err pulse 1 cycle; write 32'hFFFF_FFFF to index 100 -> all reg_q unchanged, csr_addr_err pulse.
- Read-during-write reg 5 (old 32'h0, write 32'h0000_00FF strb 4'hF): with macro -> 32'h0000_00FF; without -> 32'h0, next read 32'h0000_00FF.
- Reset mid-stream: alternating reads/writes with rst asserted one cycle -> requests in that cycle dropped, state equals reset state, traffic resumes next cycle.
